// File: rtl/fp_to_int_seq_if.sv
// Handshake bundle for fp_to_int_seq: operand request channel plus result/flag channel.
interface fp_to_int_seq_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned INT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic                 out_valid;
  logic                 out_ready;
  logic [INT_WIDTH-1:0] result;
  logic                 invalid;
  logic                 overflow;
  logic                 inexact;

  modport master (output in_valid, a, out_ready,
                  input  in_ready, out_valid, result, invalid, overflow, inexact);
  modport slave  (input  in_valid, a, out_ready,
                  output in_ready, out_valid, result, invalid, overflow, inexact);
endinterface

// File: rtl/fp_to_int_seq.sv
// Iterative IEEE-754 single -> signed integer converter, one bit of shift per cycle.
// Define FP2INT_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module fp_to_int_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MANT_BITS = 23,
  parameter int unsigned INT_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_to_int_seq_if.slave bus
);
  localparam int unsigned BIAS      = (1 << (EXP_BITS - 1)) - 1;
  localparam int unsigned HALF_EXP  = BIAS - 1;                // e = -1
  localparam int unsigned ALIGN_EXP = BIAS + MANT_BITS;        // e = MANT_BITS, no shift
  localparam int unsigned SAT_EXP   = BIAS + INT_WIDTH - 1;    // e = INT_WIDTH-1
  localparam int unsigned SIG_W     = MANT_BITS + 1;
  localparam int unsigned CNT_W     = $clog2(SIG_W + 1);
  localparam logic [EXP_BITS-1:0]  EXP_MAX = '1;
  localparam logic [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 sign_q, sign_d, left_q, left_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [INT_WIDTH-1:0] mag_q, mag_d;
  logic                 guard_q, guard_d, sticky_q, sticky_d;
  logic [INT_WIDTH-1:0] result_q, result_d;
  logic                 invalid_q, invalid_d, overflow_q, overflow_d, inexact_q, inexact_d;
  logic                 out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  logic                 sign_w;
  logic [EXP_BITS-1:0]  exp_w;
  logic [MANT_BITS-1:0] mant_w;
  logic                 special_c, spec_inv_c, spec_ovf_c, spec_inx_c, left_c, inc_c;
  logic [INT_WIDTH-1:0] spec_res_c, mag_rnd_c;
  logic [CNT_W-1:0]     cnt_c;

  assign sign_w = bus.a[WIDTH-1];
  assign exp_w  = bus.a[WIDTH-2 -: EXP_BITS];
  assign mant_w = bus.a[MANT_BITS-1:0];

  // Operand classification; only consumed on the accept edge
  always_comb begin
    special_c  = 1'b1;
    spec_res_c = '0;
    spec_inv_c = 1'b0;
    spec_ovf_c = 1'b0;
    spec_inx_c = 1'b0;
    left_c     = 1'b0;
    cnt_c      = '0;
    if (exp_w == EXP_MAX) begin
      spec_inv_c = 1'b1;
      spec_res_c = (sign_w && mant_w == '0) ? INT_MIN : INT_MAX;
    end else if (exp_w == '0) begin
      spec_inx_c = (mant_w != '0);
    end else if (exp_w < EXP_BITS'(HALF_EXP)) begin
      spec_inx_c = 1'b1;
    end else if (exp_w >= EXP_BITS'(SAT_EXP)) begin
      if (sign_w && exp_w == EXP_BITS'(SAT_EXP) && mant_w == '0) begin
        spec_res_c = INT_MIN;
      end else begin
        spec_res_c = sign_w ? INT_MIN : INT_MAX;
        spec_ovf_c = 1'b1;
      end
    end else begin
      special_c = 1'b0;
      left_c    = (exp_w >= EXP_BITS'(ALIGN_EXP));
      cnt_c     = left_c ? CNT_W'(exp_w - EXP_BITS'(ALIGN_EXP))
                         : CNT_W'(EXP_BITS'(ALIGN_EXP) - exp_w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid)
                 state_d = special_c ? S_DONE : ((cnt_c == '0) ? S_ROUND : S_SHIFT);
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-state
  always_comb begin
    sign_d      = sign_q;
    left_d      = left_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    result_d    = result_q;
    invalid_d   = invalid_q;
    overflow_d  = overflow_q;
    inexact_d   = inexact_q;
    out_valid_d = out_valid_q;
    inc_c       = 1'b0;
    mag_rnd_c   = mag_q;
    in_ready_d  = (state_d == S_IDLE);
    case (state_q)
      S_IDLE: if (bus.in_valid) begin
        sign_d   = sign_w;
        left_d   = left_c;
        cnt_d    = cnt_c;
        mag_d    = INT_WIDTH'({1'b1, mant_w});
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        if (special_c) begin
          result_d    = spec_res_c;
          invalid_d   = spec_inv_c;
          overflow_d  = spec_ovf_c;
          inexact_d   = spec_inx_c;
          out_valid_d = 1'b1;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (left_q) begin
          mag_d = {mag_q[INT_WIDTH-2:0], 1'b0};
        end else begin
          mag_d    = {1'b0, mag_q[INT_WIDTH-1:1]};
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
      end
      S_ROUND: begin
`ifdef FP2INT_RNE_EN
        inc_c = guard_q & (sticky_q | mag_q[0]);
`else
        inc_c = 1'b0;
`endif
        mag_rnd_c   = mag_q + INT_WIDTH'(inc_c);
        result_d    = sign_q ? (INT_WIDTH'(0) - mag_rnd_c) : mag_rnd_c;
        invalid_d   = 1'b0;
        overflow_d  = 1'b0;
        inexact_d   = guard_q | sticky_q;
        out_valid_d = 1'b1;
      end
      S_DONE: if (bus.out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      left_q      <= 1'b0;
      cnt_q       <= '0;
      mag_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      result_q    <= '0;
      invalid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      inexact_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      sign_q      <= sign_d;
      left_q      <= left_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      result_q    <= result_d;
      invalid_q   <= invalid_d;
      overflow_q  <= overflow_d;
      inexact_q   <= inexact_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.invalid   = invalid_q;
  assign bus.overflow  = overflow_q;
  assign bus.inexact   = inexact_q;
endmodule
